// File: rtl/johnson_phase_decoder_if.sv
// Bus between a 4-bit Johnson counter and its phase decoder.
// The counter side drives count; the decoder side returns registered status.
interface johnson_phase_decoder_if #(
    parameter int unsigned LAP_W = 8
);
    logic [3:0]       count;
    logic [2:0]       phase;
    logic [7:0]       phase_onehot;
    logic             valid;
    logic             illegal;
    logic             seq_err;
    logic             err_sticky;
    logic             lap_pulse;
    logic [LAP_W-1:0] lap_count;

    modport master (
        output count,
        input  phase, phase_onehot, valid, illegal, seq_err, err_sticky, lap_pulse, lap_count
    );

    modport slave (
        input  count,
        output phase, phase_onehot, valid, illegal, seq_err, err_sticky, lap_pulse, lap_count
    );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Decodes a 4-bit Johnson counter into phase index / one-hot strobe, flags
// out-of-ring codes and mis-sequencing, and counts completed 7->0 laps.
module johnson_phase_decoder #(
    parameter int unsigned LAP_W      = 8,
    parameter int unsigned ALLOW_HOLD = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    johnson_phase_decoder_if.slave bus
);

    logic             w_legal;
    logic [2:0]       w_phase;
    logic [2:0]       w_next_exp;
    logic             w_step;
    logic             w_hold;

    logic [2:0]       r_phase;
    logic [7:0]       r_phase_onehot;
    logic             r_valid;
    logic             r_illegal;
    logic             r_seq_err;
    logic             r_err_sticky;
    logic             r_lap_pulse;
    logic [LAP_W-1:0] r_lap_count;
    logic [2:0]       r_prev_phase;
    logic             r_have_prev;

    // Ring lookup: eight legal codes, everything else is outside the ring.
    always_comb begin
        w_legal = 1'b1;
        w_phase = 3'd0;
        case (bus.count)
            4'b0000: w_phase = 3'd0;
            4'b0001: w_phase = 3'd1;
            4'b0011: w_phase = 3'd2;
            4'b0111: w_phase = 3'd3;
            4'b1111: w_phase = 3'd4;
            4'b1110: w_phase = 3'd5;
            4'b1100: w_phase = 3'd6;
            4'b1000: w_phase = 3'd7;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_next_exp = 3'(r_prev_phase + 3'd1);
    assign w_step     = (w_phase == w_next_exp);
    assign w_hold     = (ALLOW_HOLD != 0) && (w_phase == r_prev_phase);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase        <= 3'd0;
            r_phase_onehot <= 8'd0;
            r_valid        <= 1'b0;
            r_illegal      <= 1'b0;
            r_seq_err      <= 1'b0;
            r_err_sticky   <= 1'b0;
            r_lap_pulse    <= 1'b0;
            r_lap_count    <= '0;
            r_prev_phase   <= 3'd0;
            r_have_prev    <= 1'b0;
        end else if (w_legal) begin
            r_phase        <= w_phase;
            r_phase_onehot <= 8'b1 << w_phase;
            r_valid        <= 1'b1;
            r_illegal      <= 1'b0;
            r_seq_err      <= 1'b0;
            r_lap_pulse    <= 1'b0;
            r_prev_phase   <= w_phase;
            r_have_prev    <= 1'b1;
            // A resync sample (no predecessor) is never checked nor counted.
            if (r_have_prev) begin
                if (w_step) begin
                    if (r_prev_phase == 3'd7) begin
                        r_lap_pulse <= 1'b1;
                        r_lap_count <= r_lap_count + LAP_W'(1);
                    end
                end else if (!w_hold) begin
                    r_seq_err    <= 1'b1;
                    r_err_sticky <= 1'b1;
                end
            end
        end else begin
            r_phase_onehot <= 8'd0;
            r_valid        <= 1'b0;
            r_illegal      <= 1'b1;
            r_seq_err      <= 1'b0;
            r_lap_pulse    <= 1'b0;
            r_err_sticky   <= 1'b1;
            r_have_prev    <= 1'b0;
        end
    end

    assign bus.phase        = r_phase;
    assign bus.phase_onehot = r_phase_onehot;
    assign bus.valid        = r_valid;
    assign bus.illegal      = r_illegal;
    assign bus.seq_err      = r_seq_err;
    assign bus.err_sticky   = r_err_sticky;
    assign bus.lap_pulse    = r_lap_pulse;
    assign bus.lap_count    = r_lap_count;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Scoreboard bench: two decoder variants (strict 8-bit laps, hold-tolerant 2-bit laps)
// share one count stream; a ring-table model predicts every registered output.
module tb_johnson_phase_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cnt;

    always #5 clk = ~clk;

    johnson_phase_decoder_if #(.LAP_W(8)) if_a ();
    johnson_phase_decoder_if #(.LAP_W(2)) if_b ();

    assign if_a.count = cnt;
    assign if_b.count = cnt;

    johnson_phase_decoder #(.LAP_W(8), .ALLOW_HOLD(0)) u_a (.clk(clk), .reset(reset), .bus(if_a));
    johnson_phase_decoder #(.LAP_W(2), .ALLOW_HOLD(1)) u_b (.clk(clk), .reset(reset), .bus(if_b));

    logic [3:0] ring [8];
    initial begin
        ring[0] = 4'b0000; ring[1] = 4'b0001; ring[2] = 4'b0011; ring[3] = 4'b0111;
        ring[4] = 4'b1111; ring[5] = 4'b1110; ring[6] = 4'b1100; ring[7] = 4'b1000;
    end

    // Expected vector: {phase, onehot, valid, illegal, seq_err, sticky, lap_pulse, lap[7:0]}
    logic [23:0] q_a[$];
    logic [23:0] q_b[$];

    int m_prev  [2];
    bit m_have  [2];
    int m_lap   [2];
    bit m_sticky[2];
    int m_phase [2];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int ring_index(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (ring[i] == c) return i;
        return -1;
    endfunction

    task automatic model_step(input int k, input bit rst, input logic [3:0] c);
        int  p;
        bit  hold_ok, v, ill, serr, lp;
        int  lapmod;
        logic [23:0] e;
        hold_ok = (k == 1);
        lapmod  = (k == 1) ? 4 : 256;
        p = ring_index(c);
        v = 0; ill = 0; serr = 0; lp = 0;
        if (rst) begin
            m_prev[k] = 0; m_have[k] = 0; m_lap[k] = 0; m_sticky[k] = 0; m_phase[k] = 0;
        end else if (p < 0) begin
            ill = 1; m_sticky[k] = 1; m_have[k] = 0;
        end else begin
            v = 1;
            if (m_have[k]) begin
                if (p == (m_prev[k] + 1) % 8) begin
                    if (m_prev[k] == 7) begin
                        lp = 1;
                        m_lap[k] = (m_lap[k] + 1) % lapmod;
                    end
                end else if (!(hold_ok && p == m_prev[k])) begin
                    serr = 1; m_sticky[k] = 1;
                end
            end
            m_phase[k] = p; m_prev[k] = p; m_have[k] = 1;
        end
        e = {3'(m_phase[k]), (v ? 8'(1 << m_phase[k]) : 8'd0), v, ill, serr, m_sticky[k], lp, 8'(m_lap[k])};
        if (k == 0) q_a.push_back(e); else q_b.push_back(e);
    endtask

    // Drive one sample on the falling edge and predict the outputs after the next rise.
    task automatic step(input bit rst, input logic [3:0] c);
        @(negedge clk);
        reset = rst;
        cnt   = c;
        model_step(0, rst, c);
        model_step(1, rst, c);
    endtask

    task automatic compare(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got ph=%0d oh=%02h v=%b il=%b se=%b st=%b lp=%b lap=%0d, want ph=%0d oh=%02h v=%b il=%b se=%b st=%b lp=%b lap=%0d",
                      name, $time, act[23:21], act[20:13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                      exp[23:21], exp[20:13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    endtask

    // Monitor: outputs are registered, so sample just after every rising edge.
    initial begin
        logic [23:0] act_a, act_b;
        forever begin
            @(posedge clk);
            #1;
            act_a = {if_a.phase, if_a.phase_onehot, if_a.valid, if_a.illegal, if_a.seq_err,
                     if_a.err_sticky, if_a.lap_pulse, if_a.lap_count};
            act_b = {if_b.phase, if_b.phase_onehot, if_b.valid, if_b.illegal, if_b.seq_err,
                     if_b.err_sticky, if_b.lap_pulse, 8'(if_b.lap_count)};
            if (q_a.size() > 0) compare("strict", act_a, q_a.pop_front());
            if (q_b.size() > 0) compare("hold_lap2", act_b, q_b.pop_front());
        end
    end

    initial begin
        int cur;
        int r;
        reset = 1'b1;
        cnt   = 4'b0000;

        // Reset two cycles, then 20 clean ring steps (two laps).
        step(1, 4'b0000);
        step(1, 4'b0000);
        for (int i = 0; i < 20; i++) step(0, ring[i % 8]);
        // Out-of-ring code mid-run, then resync on 0011.
        step(0, 4'b0101);
        step(0, 4'b0011);
        // Skip 0001 -> 0111.
        for (int i = 3; i < 10; i++) step(0, ring[i % 8]);
        step(0, 4'b0111);
        step(0, 4'b1111);
        // Hold 0011 for three cycles after a resync.
        step(0, 4'b0101);
        for (int i = 0; i < 3; i++) step(0, 4'b0011);
        // Five full laps from a clean reset.
        step(1, 4'b0000);
        for (int i = 0; i <= 40; i++) step(0, ring[i % 8]);
        // Reset at phase 5 with three laps done, then resync on 1100.
        step(1, 4'b0000);
        for (int i = 0; i <= 29; i++) step(0, ring[i % 8]);
        step(1, ring[5]);
        step(0, 4'b1100);
        step(0, 4'b1000);
        step(0, 4'b0000);

        // Random walk biased towards legal advances.
        cur = 0;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(99, 0));
            if (r < 60)      cur = (cur + 1) % 8;
            else if (r < 70) cur = cur;
            else if (r < 80) cur = int'($urandom_range(7, 0));
            if (r >= 97) begin
                step(1, ring[cur]);
            end else if (r >= 85) begin
                step(0, 4'($urandom_range(15, 0)));
            end else begin
                step(0, ring[cur]);
            end
        end

        for (int i = 0; i < 20 && (q_a.size() > 0 || q_b.size() > 0); i++) @(negedge clk);
        if (q_a.size() > 0 || q_b.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d/%0d expectations left, want 0/0", q_a.size(), q_b.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/johnson_phase_decoder.md
# johnson_phase_decoder

Downstream consumer of the 4-bit Johnson counter's `count` bus. It registers each sample and decodes it into a phase index and a one-hot phase strobe. It also flags codes outside the 8-state Johnson ring, checks that the sequence advances legally, and counts completed laps. Downstream logic and the bench use it to drive phase-selected outputs and to self-check the counter.

## Interface
- `LAP_W`, default 8: width of the lap counter.
- `ALLOW_HOLD`, default 0: if 1, repeating the same legal code on consecutive cycles is not a sequence error.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: rising-edge clock, shared with the Johnson counter.
- `reset` in 1: synchronous, active-high; clears all state.
- `count` in 4: Johnson counter state.
- `phase` out 3: decoded phase index 0–7.
- `phase_onehot` out 8: `1 << phase` when `valid`, else 0.
- `valid` out 1: the last sample was a legal Johnson code.
- `illegal` out 1: the last sample was not a legal Johnson code.
- `seq_err` out 1: one-cycle pulse; a legal code did not follow its predecessor.
- `err_sticky` out 1: set by any `illegal` or `seq_err`; cleared only by `reset`.
- `lap_pulse` out 1: one-cycle pulse on a legal phase 7→0 step.
- `lap_count` out `LAP_W`: number of completed laps, wraps modulo 2^`LAP_W`.

## Operation
- Legal ring and phase mapping: 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7.
- The other 8 codes are illegal: 0010, 0100, 0101, 0110, 1001, 1010, 1011, 1101.
- Internal state:
  - `prev_phase[2:0]`: phase of the last legal sample.
  - `have_prev`: set when the last sample was legal.
- Each rising edge with `reset`=0, if `count` is legal with phase P:
  - `valid`=1, `illegal`=0, `phase`=P, `phase_onehot`=1<<P.
  - If `have_prev`=0: no check.
  - Else, expected next phase E = (`prev_phase`+1) mod 8.
    - P==E: correct step.
    - P==`prev_phase` and `ALLOW_HOLD`=1: correct hold, no lap.
    - Anything else: `seq_err`=1 for one cycle and `err_sticky`<=1.
  - Correct step with `prev_phase`=7 and P=0: `lap_pulse`=1 and `lap_count`<=`lap_count`+1.
  - Update: `prev_phase`<=P, `have_prev`<=1.
- Each rising edge with `reset`=0, if `count` is illegal:
  - `valid`=0, `illegal`=1, `phase_onehot`=0, `phase` holds its last value.
  - `err_sticky`<=1, `have_prev`<=0.
  - No `seq_err` and no `lap_pulse` on this cycle.
- First legal sample after reset or after an illegal code: only resynchronises the checker. It never raises `seq_err` or `lap_pulse`, even when P=0.
- `seq_err` and `lap_pulse` are mutually exclusive. A mis-sequenced 0 after 6 is an error, not a lap.
- `lap_count` wraps from 2^`LAP_W`−1 to 0 silently; this is not an error.

## Timing
- Every output is a register; there is no combinational path from `count` to any output.
- Latency is 1 cycle: the `count` value sampled at edge N appears on the outputs after edge N.
- Reset values (applied on the first edge with `reset`=1):
  - `phase`=0, `phase_onehot`=0, `lap_count`=0, `have_prev`=0.
  - `valid`, `illegal`, `seq_err`, `err_sticky`, `lap_pulse` all 0.
- `reset` takes priority over all other updates.
- Reset asserted mid-lap: the next edge clears everything. After release, the first sample is treated as a resync sample.
- Every `count` value, legal or illegal, is classified independently. There are no blackout cycles.

## Test plan
- Reset held 2 cycles with `count`=0000, then the counter runs 20 cycles from 0000:
  - `phase` steps 0,1,…,7,0,…
  - `phase_onehot` follows: 0x01, 0x02, …, 0x80, 0x01.
  - No `seq_err`; `lap_pulse` twice; `lap_count`=2.
  - Check the 1-cycle latency against `count`.
- Force `count`=0101 for one cycle mid-run:
  - Next cycle: `illegal`=1, `valid`=0, `phase_onehot`=0, `phase` held, `err_sticky`=1.
  - Next legal sample (e.g. 0011): `phase`=2, no `seq_err`.
- Skip a state, sequence 0001→0111:
  - `seq_err`=1 for exactly 1 cycle; `err_sticky`=1; `lap_count` unchanged.
- Hold `count`=0011 for 3 cycles:
  - `ALLOW_HOLD`=0: `seq_err` pulses on cycles 2 and 3.
  - `ALLOW_HOLD`=1: no error.
- With `LAP_W`=2, run 5 full laps:
  - `lap_count` goes 1,2,3,0,1; `err_sticky` stays 0.
- Assert `reset` for 1 cycle at phase 5 (`lap_count`=3):
  - All outputs return to reset values.
  - The next sample 1100 decodes as `phase`=6 with no `seq_err`.
